// File: rtl/fp_sign_pkg.sv
// Shared types for the FP add/sub sign stage.
//   fp_class_e : operand/result class (NORM must stay 0: it is the reset value of res_cls)
//   rmode_e    : rounding mode, shared by all lanes
//   lane_in_t  : per-lane decision inputs
//   lane_out_t : per-lane decision result, carried down the pipeline
package fp_sign_pkg;

  typedef enum logic [1:0] {NORM = 2'd0, ZERO = 2'd1, INF = 2'd2, NAN = 2'd3} fp_class_e;
  typedef enum logic [1:0] {RNE = 2'd0, RTZ = 2'd1, RDN = 2'd2, RUP = 2'd3} rmode_e;

  typedef struct packed {
    logic      sign_a;
    logic      sign_b;
    logic      op;       // 0: A+B, 1: A-B
    fp_class_e cls_a;
    fp_class_e cls_b;
    logic      a_ge_b;   // |A| >= |B|
    logic      mag_eq;   // |A| == |B|
  } lane_in_t;

  typedef struct packed {
    logic      eff_sub;
    logic      res_sign;
    fp_class_e res_cls;
    logic      invalid;
  } lane_out_t;

endpackage

// File: rtl/fp_sign_lane.sv
// Combinational sign / effective-operation decision for one lane.
//   li : operand signs, op, classes and magnitude compare
//   rm : rounding mode (only matters for the sign of an exact cancellation)
//   lo : eff_sub, res_sign, res_cls, invalid
module fp_sign_lane
  import fp_sign_pkg::*;
(
  input  lane_in_t  li,
  input  rmode_e    rm,
  output lane_out_t lo
);

  logic sbe;
  logic a_inf, b_inf, any_nan;

  always_comb begin
    // B's sign as seen by an addition: subtracting flips it
    sbe     = li.sign_b ^ li.op;
    a_inf   = (li.cls_a == INF);
    b_inf   = (li.cls_b == INF);
    any_nan = (li.cls_a == NAN) | (li.cls_b == NAN);

    lo.eff_sub  = li.sign_a ^ sbe;
    lo.res_sign = 1'b0;
    lo.res_cls  = NORM;
    lo.invalid  = 1'b0;

    if (any_nan) begin
      lo.res_cls = NAN;
    end else if (a_inf & b_inf) begin
      if (lo.eff_sub) begin
        // inf - inf has no meaningful value
        lo.res_cls = NAN;
        lo.invalid = 1'b1;
      end else begin
        lo.res_cls  = INF;
        lo.res_sign = li.sign_a;
      end
    end else if (a_inf) begin
      lo.res_cls  = INF;
      lo.res_sign = li.sign_a;
    end else if (b_inf) begin
      lo.res_cls  = INF;
      lo.res_sign = sbe;
    end else if (!lo.eff_sub) begin
      // same effective signs: magnitude grows, sign is A's (also gives -0 + -0 = -0)
      lo.res_sign = li.sign_a;
    end else if (li.mag_eq) begin
      // exact cancellation: +0 except when rounding toward -inf
      lo.res_cls  = ZERO;
      lo.res_sign = (rm == RDN);
    end else begin
      lo.res_sign = li.a_ge_b ? li.sign_a : sbe;
    end
  end

endmodule

// File: rtl/fp_sign_pipe.sv
// Multi-lane pipelined sign/effective-operation stage of the FP adder.
// The lane decisions are made in front of stage 0; stages behind it are plain
// registers so the latency (STAGES) matches the mantissa align/add path.
// Ports:
//   clk, rst (sync, active high), flush (sync, drops all in-flight beats)
//   in_valid/in_ready/in_tag, rm, op/sign_a/sign_b/cls_a/cls_b/a_ge_b/mag_eq : input beat
//   out_valid/out_ready/out_tag, eff_sub/res_sign/res_cls/invalid            : output beat
//   inv_sticky : per-lane sticky invalid, set on an output handshake, cleared by clr_sticky
module fp_sign_pipe
  import fp_sign_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [1:0]           rm,
  input  logic [LANES-1:0]     op,
  input  logic [LANES-1:0]     sign_a,
  input  logic [LANES-1:0]     sign_b,
  input  logic [2*LANES-1:0]   cls_a,
  input  logic [2*LANES-1:0]   cls_b,
  input  logic [LANES-1:0]     a_ge_b,
  input  logic [LANES-1:0]     mag_eq,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [LANES-1:0]     eff_sub,
  output logic [LANES-1:0]     res_sign,
  output logic [2*LANES-1:0]   res_cls,
  output logic [LANES-1:0]     invalid,
  output logic [LANES-1:0]     inv_sticky,
  input  logic                 clr_sticky
);

  localparam int LAST = STAGES - 1;

  rmode_e                  rm_e;
  lane_in_t  [LANES-1:0]   lin;
  lane_out_t [LANES-1:0]   lout;

  logic [STAGES-1:0]       vld_q, vld_d;
  logic [STAGES-1:0]       load;      // stage may take new contents this cycle
  logic [TAG_W-1:0]        tag_q [STAGES];
  logic [TAG_W-1:0]        tag_d [STAGES];
  lane_out_t [LANES-1:0]   lo_q  [STAGES];
  lane_out_t [LANES-1:0]   lo_d  [STAGES];
  logic [LANES-1:0]        sticky_q, sticky_d;
  logic [LANES-1:0]        inv_set;
  logic                    in_fire, out_fire;

  assign rm_e = rmode_e'(rm);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lin[i] = '{sign_a: sign_a[i],
                      sign_b: sign_b[i],
                      op:     op[i],
                      cls_a:  fp_class_e'(cls_a[2*i +: 2]),
                      cls_b:  fp_class_e'(cls_b[2*i +: 2]),
                      a_ge_b: a_ge_b[i],
                      mag_eq: mag_eq[i]};

    fp_sign_lane u_lane (
      .li (lin[i]),
      .rm (rm_e),
      .lo (lout[i])
    );

    assign eff_sub[i]         = lo_q[LAST][i].eff_sub;
    assign res_sign[i]        = lo_q[LAST][i].res_sign;
    assign res_cls[2*i +: 2]  = lo_q[LAST][i].res_cls;
    assign invalid[i]         = lo_q[LAST][i].invalid;
    assign inv_set[i]         = out_fire & lo_q[LAST][i].invalid;
  end

  // Ready ripples back from the output: a stage can load if it is empty or
  // its contents move on this cycle.
  always_comb begin
    logic nxt;
    nxt = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      nxt     = ~vld_q[k] | nxt;
      load[k] = nxt;
    end
  end

  assign in_ready  = ~rst & ~flush & load[0];
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_fire  = vld_q[LAST] & out_ready;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    lo_d  = lo_q;

    if (load[0]) begin
      vld_d[0] = in_fire;
      if (in_fire) begin
        tag_d[0] = in_tag;
        lo_d[0]  = lout;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
        lo_d[k]  = lo_q[k-1];
      end
    end

    if (flush) vld_d = '0;

    // a set on this cycle beats a clear; clr_sticky has no effect during flush
    sticky_d = inv_set | (sticky_q & ~{LANES{clr_sticky & ~flush}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      sticky_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k] <= '0;
        lo_q[k]  <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      sticky_q <= sticky_d;
      tag_q    <= tag_d;
      lo_q     <= lo_d;
    end
  end

  assign inv_sticky = sticky_q;

endmodule

// File: tb/tb_fp_sign_pipe.sv
// Bench for fp_sign_pipe: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a value-level reference model and scoreboard.
module tb_fp_sign_pipe;
  import fp_sign_pkg::*;

  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, flush, in_valid, in_ready, out_valid, out_ready, clr_sticky;
  logic [TAG_W-1:0]    in_tag, out_tag;
  logic [1:0]          rm;
  logic [LANES-1:0]    op, sign_a, sign_b, a_ge_b, mag_eq;
  logic [2*LANES-1:0]  cls_a, cls_b, res_cls;
  logic [LANES-1:0]    eff_sub, res_sign, invalid, inv_sticky;

  fp_sign_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .rm(rm), .op(op), .sign_a(sign_a), .sign_b(sign_b),
    .cls_a(cls_a), .cls_b(cls_b), .a_ge_b(a_ge_b), .mag_eq(mag_eq),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .eff_sub(eff_sub), .res_sign(res_sign), .res_cls(res_cls), .invalid(invalid),
    .inv_sticky(inv_sticky), .clr_sticky(clr_sticky)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       sa, sb, op;
    logic [1:0] ca, cb;
    logic       ge, eq;
    logic [1:0] rmv;
    logic       e_eff, e_sgn, e_inv;
    logic [1:0] e_cls;
  } vec_t;

  typedef struct {
    logic [3:0] eff, sgn, inv;
    logic [7:0] cls;
    logic [3:0] tag;
  } beat_t;

  vec_t  tbl [12];
  beat_t q [$];

  // Reference: treat finite operands as signed integers and look at the sum.
  function automatic void lane_model(input logic sa, input logic sb, input logic opv,
                                     input logic [1:0] ca, input logic [1:0] cb,
                                     input int ma, input int mb, input logic [1:0] rmv,
                                     output logic eff, output logic sgn,
                                     output logic inv, output logic [1:0] cls);
    logic sbe;
    int   va, vb, s;
    sbe = sb ^ opv;
    eff = sa ^ sbe;
    sgn = 1'b0; inv = 1'b0; cls = NORM;
    if (ca == NAN || cb == NAN) begin
      cls = NAN;
    end else if (ca == INF || cb == INF) begin
      if (ca == INF && cb == INF && sa != sbe) begin
        cls = NAN; inv = 1'b1;
      end else begin
        cls = INF;
        sgn = (ca == INF) ? sa : sbe;
      end
    end else begin
      va = sa  ? -ma : ma;
      vb = sbe ? -mb : mb;
      s  = va + vb;
      if (s == 0) begin
        if (sa == sbe) sgn = sa;
        else begin cls = ZERO; sgn = (rmv == RDN); end
      end else begin
        sgn = (s < 0);
      end
    end
  endfunction

  task automatic apply_vec(input vec_t v);
    sign_a = {LANES{v.sa}};  sign_b = {LANES{v.sb}};  op = {LANES{v.op}};
    cls_a  = {LANES{v.ca}};  cls_b  = {LANES{v.cb}};
    a_ge_b = {LANES{v.ge}};  mag_eq = {LANES{v.eq}};  rm = v.rmv;
  endtask

  // Drive one beat with lane inputs already applied, wait for it at the output
  // (out_ready=1), check it and its latency, then step past the handshake.
  task automatic send_one(input string nm, input logic [3:0] tag, input bit clr_at_out,
                          input vec_t v);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1; in_tag = tag; out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, "_latency"}, 32'(cnt), 32'(STAGES));
    if (clr_at_out) clr_sticky = 1'b1;
    chk({nm, "_out"}, 32'({eff_sub, res_sign, invalid, res_cls, out_tag}),
        32'({{LANES{v.e_eff}}, {LANES{v.e_sgn}}, {LANES{v.e_inv}}, {LANES{v.e_cls}}, tag}));
    @(negedge clk);
    clr_sticky = 1'b0;
  endtask

  initial begin
    logic [3:0]  stk;
    logic [23:0] snap;
    bit          prev_stall;
    int          sent, got, cyc;
    bit          ifire, ofire, feeding;
    logic [3:0]  ra, rb, rop, rge, req;
    logic [7:0]  rca, rcb;
    logic [1:0]  rrm;
    logic [3:0]  sticky_m;
    beat_t       eb;

    tbl[0]  = '{1'b0,1'b1,1'b0,NORM,NORM,1'b0,1'b0,RNE, 1'b1,1'b1,1'b0,NORM};
    tbl[1]  = '{1'b0,1'b1,1'b1,NORM,NORM,1'b0,1'b0,RNE, 1'b0,1'b0,1'b0,NORM};
    tbl[2]  = '{1'b0,1'b0,1'b1,NORM,NORM,1'b1,1'b1,RNE, 1'b1,1'b0,1'b0,ZERO};
    tbl[3]  = '{1'b0,1'b0,1'b1,NORM,NORM,1'b1,1'b1,RDN, 1'b1,1'b1,1'b0,ZERO};
    tbl[4]  = '{1'b1,1'b1,1'b0,ZERO,ZERO,1'b1,1'b1,RNE, 1'b0,1'b1,1'b0,NORM};
    tbl[5]  = '{1'b0,1'b0,1'b1,INF, INF, 1'b1,1'b1,RNE, 1'b1,1'b0,1'b1,NAN};
    tbl[6]  = '{1'b1,1'b0,1'b0,NAN, NORM,1'b1,1'b0,RUP, 1'b1,1'b0,1'b0,NAN};
    tbl[7]  = '{1'b0,1'b0,1'b1,NORM,INF, 1'b0,1'b0,RNE, 1'b1,1'b1,1'b0,INF};
    tbl[8]  = '{1'b1,1'b1,1'b0,INF, INF, 1'b1,1'b1,RTZ, 1'b0,1'b1,1'b0,INF};
    tbl[9]  = '{1'b1,1'b1,1'b1,NORM,NORM,1'b1,1'b0,RNE, 1'b1,1'b1,1'b0,NORM};
    tbl[10] = '{1'b0,1'b1,1'b0,ZERO,ZERO,1'b1,1'b1,RDN, 1'b1,1'b1,1'b0,ZERO};
    tbl[11] = '{1'b1,1'b0,1'b0,NORM,NORM,1'b1,1'b1,RUP, 1'b1,1'b0,1'b0,ZERO};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    in_tag = '0; apply_vec(tbl[0]);
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_outs", 32'({out_valid, out_tag, eff_sub, res_sign, invalid, res_cls, inv_sticky}), 32'd0);
    rst = 1'b0;

    // vector table
    stk = '0;
    for (int i = 0; i < 12; i++) begin
      apply_vec(tbl[i]);
      send_one($sformatf("vec%0d", i), 4'(i), 1'b0, tbl[i]);
      if (tbl[i].e_inv) stk = '1;
      chk($sformatf("vec%0d_sticky", i), 32'(inv_sticky), 32'(stk));
    end

    // sticky: clear alone, then clear colliding with a set
    clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    chk("sticky_clr", 32'(inv_sticky), 32'd0);
    apply_vec(tbl[5]);
    send_one("clr_vs_set", 4'd3, 1'b1, tbl[5]);
    chk("sticky_set_wins", 32'(inv_sticky), 32'hF);
    clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    chk("sticky_clr2", 32'(inv_sticky), 32'd0);

    // backpressure: 10 beats, out_ready 1,0,0,1
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; snap = '0;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      if (prev_stall)
        chk("bp_hold", 32'({out_valid, out_tag, eff_sub, res_sign, invalid, res_cls}), 32'({1'b1, snap}));
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (sent < 10);
      in_tag    = sent[3:0];
      apply_vec(tbl[sent % 12]);
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("bp_tag", 32'(out_tag), 32'(got));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      snap = {out_tag, eff_sub, res_sign, invalid, res_cls};
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(got), 32'd10);
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // flush with two beats in flight and in_valid high
    out_ready = 1'b0; apply_vec(tbl[0]);
    @(negedge clk); in_valid = 1'b1; in_tag = 4'd1;
    @(negedge clk); in_tag = 4'd2;
    @(negedge clk);
    chk("flush_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_tag = 4'd3;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    send_one("post_flush", 4'd4, 1'b0, tbl[0]);

    // reset mid-stream with a beat presented and sticky set
    apply_vec(tbl[5]);
    send_one("pre_rst", 4'd6, 1'b0, tbl[5]);
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_tag = 4'd7;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre", 32'({out_valid, inv_sticky}), 32'h1F);
    rst = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst_outs", 32'({out_valid, out_tag, eff_sub, res_sign, invalid, res_cls, inv_sticky}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("rst_release_ready", 32'(in_ready), 32'd1);

    // randomized traffic against the reference model
    sticky_m = '0;
    for (int c = 0; c < 430; c++) begin
      @(negedge clk);
      feeding = (c < 400);
      chk("rnd_sticky", 32'(inv_sticky), 32'(sticky_m));
      if (out_valid) begin
        if (q.size() == 0) chk("rnd_spurious", 32'(out_valid), 32'd0);
        else chk("rnd_beat", 32'({eff_sub, res_sign, invalid, res_cls, out_tag}),
                 32'({q[0].eff, q[0].sgn, q[0].inv, q[0].cls, q[0].tag}));
      end
      for (int l = 0; l < LANES; l++) begin
        int          r, ma, mb;
        logic [1:0]  ca, cb;
        r = int'($urandom_range(7, 0));
        ca = (r < 4) ? NORM : (r < 6) ? ZERO : (r == 6) ? INF : NAN;
        r = int'($urandom_range(7, 0));
        cb = (r < 4) ? NORM : (r < 6) ? ZERO : (r == 6) ? INF : NAN;
        ma = (ca == NORM) ? int'($urandom_range(3, 1)) : 0;
        mb = (cb == NORM) ? int'($urandom_range(3, 1)) : 0;
        ra[l]  = 1'($urandom); rb[l] = 1'($urandom); rop[l] = 1'($urandom);
        rca[2*l +: 2] = ca; rcb[2*l +: 2] = cb;
        if (ca == INF || ca == NAN || cb == INF || cb == NAN) begin
          rge[l] = 1'($urandom); req[l] = 1'($urandom);
        end else begin
          rge[l] = (ma >= mb); req[l] = (ma == mb);
        end
        rrm = rm;
        eb.tag = '0;
        lane_model(ra[l], rb[l], rop[l], ca, cb, ma, mb, rm,
                   eb.eff[l], eb.sgn[l], eb.inv[l], eb.cls[2*l +: 2]);
      end
      rrm = 2'($urandom);
      // model above used last cycle's rm; recompute with the rm being driven
      for (int l = 0; l < LANES; l++) begin
        int ma, mb;
        ma = (rca[2*l +: 2] == NORM) ? (rge[l] ? 2 : 1) : 0;
        mb = (rcb[2*l +: 2] == NORM) ? (req[l] ? ma : (rge[l] ? 1 : 2)) : 0;
        if (rca[2*l +: 2] == NORM && rcb[2*l +: 2] == NORM && !rge[l] && req[l]) req[l] = 1'b0;
        if (rca[2*l +: 2] == NORM && rcb[2*l +: 2] == NORM) begin
          ma = (rge[l]) ? (req[l] ? 2 : 3) : 1;
          mb = (req[l]) ? ma : 2;
          if (!rge[l]) begin ma = 1; mb = 2; end
        end
        if (rca[2*l +: 2] == ZERO && rcb[2*l +: 2] == NORM) begin rge[l] = 1'b0; req[l] = 1'b0; mb = 1; end
        if (rca[2*l +: 2] == NORM && rcb[2*l +: 2] == ZERO) begin rge[l] = 1'b1; req[l] = 1'b0; ma = 1; end
        if (rca[2*l +: 2] == ZERO && rcb[2*l +: 2] == ZERO) begin rge[l] = 1'b1; req[l] = 1'b1; end
        lane_model(ra[l], rb[l], rop[l], rca[2*l +: 2], rcb[2*l +: 2], ma, mb, rrm,
                   eb.eff[l], eb.sgn[l], eb.inv[l], eb.cls[2*l +: 2]);
      end
      sign_a = ra; sign_b = rb; op = rop; cls_a = rca; cls_b = rcb;
      a_ge_b = rge; mag_eq = req; rm = rrm;
      in_tag     = 4'($urandom);
      eb.tag     = in_tag;
      in_valid   = feeding && ($urandom_range(3, 0) != 0);
      out_ready  = !feeding || ($urandom_range(2, 0) != 0);
      clr_sticky = feeding && ($urandom_range(15, 0) == 0);
      #1;
      ifire = in_valid && in_ready;
      ofire = out_valid && out_ready;
      if (ofire && q.size() != 0) begin
        sticky_m = q[0].inv | (sticky_m & ~{LANES{clr_sticky}});
        void'(q.pop_front());
      end else begin
        sticky_m = sticky_m & ~{LANES{clr_sticky}};
      end
      if (ifire) q.push_back(eb);
    end
    in_valid = 1'b0; clr_sticky = 1'b0;
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_idle", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
